imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate-generation stage between fetch and decode/execute.
- Accepts a 32-bit RV instruction plus a tag over a valid/ready handshake.
- Produces the XLEN-wide sign/zero-extended immediate, a format code and an unknown-opcode flag one cycle later.
- Internal skid buffer keeps full throughput while giving a registered in_ready.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. 64 enables 6-bit shamt and OP-IMM-32 handling.
- TAG_W, 32, width of the sideband tag (normally PC) carried alongside the immediate.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  immediate
- out_fmt  out  3  imm_fmt_e: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7
- out_unknown  out  1  opcode not recognised
- out_tag  out  TAG_W  tag of out_imm

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, skid empty, out_imm=0, out_fmt=NONE, out_unknown=0, out_tag=0.
- Transfer occurs when valid&&ready on the same edge. Latency is exactly 1 cycle from input acceptance to out_valid. Sustained throughput is 1 per cycle while out_ready=1.
- Output register updates only when empty or out_ready=1; otherwise out_* hold stable (AXI-style, no retraction).
- Skid: if out_ready=0 while an input is accepted with the output full, the input goes to the skid entry and in_ready drops next cycle.
  - Next output pop loads from skid first.
  - in_ready returns to 1 the cycle after the skid drains.
  - Skid holds at most 1 entry; no data loss, no reordering.
- Decode is combinational ahead of the register. Sign extension is to XLEN from the top immediate bit:
  - LUI/AUIPC (0110111/0010111): U = instr[31:12]<<12, sign-extended (matters for XLEN=64).
  - JAL (1101111): J format, bit0=0.
  - JALR (1100111), LOAD (0000011): I format.
  - BRANCH (1100011): B format, bit0=0.
  - STORE (0100011): S format.
  - OP-IMM (0010011), funct3 001/101: SH format, zero-extended shamt; shamt = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64). funct7/funct6 bits are excluded from imm. All other funct3: I format.
  - OP-IMM-32 (0011011), XLEN=64 only: as OP-IMM with 5-bit shamt. XLEN=32: unknown.
  - Any other opcode: imm=0, fmt=NONE, out_unknown=1.
- Reset asserted mid-stream: all in-flight entries are discarded immediately and no out_valid glitch occurs.

Optional Feature:
- Macro IMM_GEN_ZICSR_EN.
- Defined: SYSTEM opcode 1110011 with funct3 in {101,110,111} gives fmt=Z, imm = zero-extended instr[19:15] (uimm). Other funct3 give fmt=I with the CSR address instr[31:20] zero-extended.
- Undefined: 1110011 gives fmt=NONE, imm=0, out_unknown=1.

Decomposition:
- Package imm_gen_pkg holds:
  - imm_fmt_e enum
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_SYSTEM)
  - a packed result struct {imm, fmt, unknown}
- One sub-module: imm_gen_skid, a generic 1-entry skid/pipeline register parametrised on payload width. Top level = combinational decode + imm_gen_skid.

Test Plan:
- XLEN=32, in_instr=0x12345037 (LUI) -> next cycle out_imm=0x12345000, fmt=U, unknown=0.
- in_instr=0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=B. in_instr=0x0080006F (jal +8) -> out_imm=0x00000008, fmt=J.
- in_instr=0x4030D093 (srai x1,x1,3) -> out_imm=3, fmt=SH. With XLEN=64, srai shamt 33 (instr[25:20]=33) -> out_imm=33.
- Back-to-back 4 instructions with out_ready low for cycles 2-3 -> in_ready drops after the skid fills. All 4 results appear in order with tags intact, and none are duplicated.
- in_instr=0x00000073 -> unknown=1 without IMM_GEN_ZICSR_EN. With the macro, csrrwi 0x3400D073 (uimm=1) -> out_imm=1, fmt=Z.
- rst pulsed while out_valid=1 and skid full -> out_valid=0 and in_ready=1 immediately. The first post-reset input appears after exactly 1 cycle.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and opcode constants for the immediate-generation stage.
package imm_gen_pkg;

    // Immediate format reported alongside the generated immediate
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } imm_fmt_e;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Widest supported datapath; decode always sign-extends to this width
    localparam int unsigned IMM_MAX_W = 64;

    // Decode result before registering
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 unknown;
    } imm_res_t;

endpackage

// File: rtl/imm_gen_skid.sv
// imm_gen_skid: generic 1-entry skid buffer in front of an output register.
// in_ready (o_ready) is registered; full throughput is kept while the consumer
// is ready, and one extra beat is absorbed when it stalls.
module imm_gen_skid
    import imm_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;

    logic         w_in_fire;
    logic         w_out_load;

    assign w_in_fire  = i_valid && r_in_ready;
    assign w_out_load = !r_out_valid || i_ready;

    // Output register loads from skid first, then from input; otherwise an accepted beat parks in skid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate generator (combinational decode + skid register).
// Optional: define IMM_GEN_ZICSR_EN to decode SYSTEM/CSR immediates (fmt Z / CSR address).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_unknown,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit          IS64  = (XLEN == 64);
    localparam int unsigned PAY_W = TAG_W + XLEN + 4;

    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    imm_res_t         w_res;
    logic [PAY_W-1:0] w_pay_in;
    logic [PAY_W-1:0] w_pay_out;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];

    // Immediate decode; everything is built 64 bits wide and truncated to XLEN below
    always_comb begin
        w_res = '0;
        unique case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_res.imm = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
                w_res.fmt = FMT_U;
            end
            OPC_JAL: begin
                w_res.imm = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
                w_res.fmt = FMT_J;
            end
            OPC_JALR, OPC_LOAD: begin
                w_res.imm = {{52{in_instr[31]}}, in_instr[31:20]};
                w_res.fmt = FMT_I;
            end
            OPC_BRANCH: begin
                w_res.imm = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
                w_res.fmt = FMT_B;
            end
            OPC_STORE: begin
                w_res.imm = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_res.fmt = FMT_S;
            end
            OPC_OPIMM: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    // funct7/funct6 bits never leak into the shift amount
                    if (IS64) begin
                        w_res.imm = {58'b0, in_instr[25:20]};
                    end else begin
                        w_res.imm = {59'b0, in_instr[24:20]};
                    end
                    w_res.fmt = FMT_SH;
                end else begin
                    w_res.imm = {{52{in_instr[31]}}, in_instr[31:20]};
                    w_res.fmt = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                if (!IS64) begin
                    w_res.unknown = 1'b1;
                end else if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_res.imm = {59'b0, in_instr[24:20]};
                    w_res.fmt = FMT_SH;
                end else begin
                    w_res.imm = {{52{in_instr[31]}}, in_instr[31:20]};
                    w_res.fmt = FMT_I;
                end
            end
`ifdef IMM_GEN_ZICSR_EN
            OPC_SYSTEM: begin
                if (w_f3 == 3'b101 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
                    w_res.imm = {59'b0, in_instr[19:15]};
                    w_res.fmt = FMT_Z;
                end else begin
                    w_res.imm = {52'b0, in_instr[31:20]};
                    w_res.fmt = FMT_I;
                end
            end
`else
            OPC_SYSTEM: begin
                w_res.unknown = 1'b1;
            end
`endif
            default: begin
                w_res.unknown = 1'b1;
            end
        endcase
    end

    // Upper decode bits are intentionally dropped when XLEN is narrower than 64
    generate
        if (XLEN < IMM_MAX_W) begin : g_trunc
            logic w_unused_hi;
            assign w_unused_hi = ^w_res.imm[IMM_MAX_W-1:XLEN];
        end
    endgenerate

    assign w_pay_in = {in_tag, w_res.imm[XLEN-1:0], w_res.fmt, w_res.unknown};

    imm_gen_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_pay_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_pay_out)
    );

    assign out_unknown = w_pay_out[0];
    assign out_fmt     = imm_fmt_e'(w_pay_out[3:1]);
    assign out_imm     = w_pay_out[XLEN+3:4];
    assign out_tag     = w_pay_out[PAY_W-1:XLEN+4];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 side instance).
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_unknown;
    logic [31:0] in_instr, in_tag, out_tag, out_imm;
    logic [2:0]  out_fmt;

    logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_out_unknown;
    logic [31:0] v64_in_instr;
    logic [15:0] v64_in_tag, v64_out_tag;
    logic [63:0] v64_out_imm;
    logic [2:0]  v64_out_fmt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_unknown(out_unknown), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(16)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_instr(v64_in_instr), .in_tag(v64_in_tag),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready), .out_imm(v64_out_imm),
        .out_fmt(v64_out_fmt), .out_unknown(v64_out_unknown), .out_tag(v64_out_tag)
    );

    typedef struct {
        logic [31:0] tag;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        unk;
    } exp_t;

    typedef struct {
        logic [15:0] tag;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        unk;
    } exp64_t;

    exp_t   sb[$];
    exp64_t sb64[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     occ   = 0;

    localparam int NV = 17;
    logic [31:0] v_instr [NV];
    logic [31:0] v_imm   [NV];
    logic [2:0]  v_fmt   [NV];
    logic        v_unk   [NV];

    task automatic set_vec(input int i, input logic [31:0] ins, input logic [31:0] imm,
                           input logic [2:0] fmt, input logic unk);
        v_instr[i] = ins; v_imm[i] = imm; v_fmt[i] = fmt; v_unk[i] = unk;
    endtask

    task automatic init_vectors();
        set_vec(0,  32'h12345037, 32'h12345000, 3'd4, 1'b0); // lui
        set_vec(1,  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0); // beq -4
        set_vec(2,  32'h0080006F, 32'h00000008, 3'd5, 1'b0); // jal +8
        set_vec(3,  32'h4030D093, 32'h00000003, 3'd6, 1'b0); // srai 3
        set_vec(4,  32'hFFF12083, 32'hFFFFFFFF, 3'd1, 1'b0); // lw -1
        set_vec(5,  32'h120021A3, 32'h00000123, 3'd2, 1'b0); // sw 0x123
        set_vec(6,  32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0); // auipc
        set_vec(7,  32'h80000067, 32'hFFFFF800, 3'd1, 1'b0); // jalr -2048
        set_vec(8,  32'h7FF02013, 32'h000007FF, 3'd1, 1'b0); // slti 2047
        set_vec(9,  32'h01F09093, 32'h0000001F, 3'd6, 1'b0); // slli 31
        set_vec(10, 32'h4210D093, 32'h00000001, 3'd6, 1'b0); // bit25 excluded at XLEN=32
        set_vec(11, 32'h0000001B, 32'h00000000, 3'd0, 1'b1); // OP-IMM-32 unknown at XLEN=32
        set_vec(12, 32'h00000033, 32'h00000000, 3'd0, 1'b1); // OP reg: unknown
        set_vec(15, 32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0); // jal -4
`ifdef IMM_GEN_ZICSR_EN
        set_vec(13, 32'h00000073, 32'h00000000, 3'd1, 1'b0); // ecall: I, csr 0
        set_vec(14, 32'h3400D073, 32'h00000001, 3'd7, 1'b0); // csrrwi uimm 1
        set_vec(16, 32'hF1402073, 32'h00000F14, 3'd1, 1'b0); // csrrs 0xF14 zero-extended
`else
        set_vec(13, 32'h00000073, 32'h00000000, 3'd0, 1'b1);
        set_vec(14, 32'h3400D073, 32'h00000000, 3'd0, 1'b1);
        set_vec(16, 32'hF1402073, 32'h00000000, 3'd0, 1'b1);
`endif
    endtask

    // Drive one cycle's worth of inputs on the falling edge; the next rising edge samples them
    task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                               input logic ordy);
        @(negedge clk);
        in_valid = v; in_instr = ins; in_tag = tag; out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        v64_in_valid = 1'b0; v64_in_instr = '0; v64_in_tag = '0; v64_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_imm !== 32'h0) begin n_err++; $display("FAIL rst_out_imm got=%h exp=0", out_imm); end
        n_cmp++; if (out_fmt !== 3'd0) begin n_err++; $display("FAIL rst_out_fmt got=%0d exp=0", out_fmt); end
        n_cmp++; if (out_unknown !== 1'b0) begin n_err++; $display("FAIL rst_out_unknown got=%b exp=0", out_unknown); end
        n_cmp++; if (out_tag !== 32'h0) begin n_err++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
        n_cmp++; if (v64_out_valid !== 1'b0 || v64_in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_dut64 got valid=%b ready=%b exp valid=0 ready=1", v64_out_valid, v64_in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL post_rst_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    // Stream every table vector back to back with the consumer always ready
    task automatic test_decode();
        exp_t e;
        logic acc, cons;
        int   i = 0;
        for (int c = 0; c < NV + 12; c++) begin
            logic [31:0] tg;
            tg = $urandom;
            if (i < NV) drive_cycle(1'b1, v_instr[i], tg, 1'b1);
            else        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
            n_cmp++; if (out_valid !== (occ > 0)) begin n_err++; $display("FAIL dec_out_valid cyc=%0d got=%b exp=%b", c, out_valid, occ > 0); end
            n_cmp++; if (in_ready !== (occ < 2)) begin n_err++; $display("FAIL dec_in_ready cyc=%0d got=%b exp=%b", c, in_ready, occ < 2); end
            cons = out_ready && (occ > 0);
            acc  = in_valid && (occ < 2);
            if (cons) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL dec_extra_output got tag=%h exp=none", out_tag);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (out_imm !== e.imm) begin n_err++; $display("FAIL dec_imm tag=%h got=%h exp=%h", e.tag, out_imm, e.imm); end
                    n_cmp++; if (out_fmt !== e.fmt) begin n_err++; $display("FAIL dec_fmt tag=%h got=%0d exp=%0d", e.tag, out_fmt, e.fmt); end
                    n_cmp++; if (out_unknown !== e.unk) begin n_err++; $display("FAIL dec_unknown tag=%h got=%b exp=%b", e.tag, out_unknown, e.unk); end
                    n_cmp++; if (out_tag !== e.tag) begin n_err++; $display("FAIL dec_tag got=%h exp=%h", out_tag, e.tag); end
                end
            end
            if (acc) begin
                sb.push_back('{tag: tg, imm: v_imm[i], fmt: v_fmt[i], unk: v_unk[i]});
                i++;
            end
            occ = occ + (acc ? 1 : 0) - (cons ? 1 : 0);
            if (i == NV && occ == 0 && sb.size() == 0) break;
        end
        n_cmp++; if (sb.size() != 0 || i != NV) begin
            n_err++; $display("FAIL dec_drain got pending=%0d sent=%0d exp pending=0 sent=%0d", sb.size(), i, NV);
        end
    endtask

    // Four beats with the consumer stalled on cycles 2-3: skid fills and in_ready drops
    task automatic test_back_to_back();
        exp_t e;
        logic acc, cons;
        int   i = 0;
        int   rcv = 0;
        logic saw_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            logic ordy;
            ordy = !(c == 2 || c == 3);
            if (i < 4) drive_cycle(1'b1, v_instr[i], 32'hB0 + i, ordy);
            else       drive_cycle(1'b0, 32'h0, 32'h0, ordy);
            if (in_ready === 1'b0) saw_low = 1'b1;
            n_cmp++; if (out_valid !== (occ > 0)) begin n_err++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", c, out_valid, occ > 0); end
            n_cmp++; if (in_ready !== (occ < 2)) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", c, in_ready, occ < 2); end
            cons = out_ready && (occ > 0);
            acc  = in_valid && (occ < 2);
            if (cons) begin
                rcv++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_duplicate got tag=%h exp=none", out_tag);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (out_tag !== e.tag) begin n_err++; $display("FAIL b2b_order got tag=%h exp=%h", out_tag, e.tag); end
                    n_cmp++; if (out_imm !== e.imm || out_fmt !== e.fmt) begin
                        n_err++; $display("FAIL b2b_data tag=%h got=%h/%0d exp=%h/%0d", e.tag, out_imm, out_fmt, e.imm, e.fmt);
                    end
                end
            end
            if (acc) begin
                sb.push_back('{tag: 32'hB0 + i, imm: v_imm[i], fmt: v_fmt[i], unk: v_unk[i]});
                i++;
            end
            occ = occ + (acc ? 1 : 0) - (cons ? 1 : 0);
            if (i == 4 && occ == 0) break;
        end
        n_cmp++; if (rcv != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", rcv); end
        n_cmp++; if (saw_low !== 1'b1) begin n_err++; $display("FAIL b2b_ready_drop got=%b exp=1", saw_low); end
    endtask

    // Reset with output valid and skid full; afterwards one beat must appear after exactly one cycle
    task automatic test_reset_midstream();
        drive_cycle(1'b1, v_instr[0], 32'hA0, 1'b0);
        drive_cycle(1'b1, v_instr[1], 32'hA1, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_full got valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
        sb.delete();
        occ = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, v_instr[2], 32'hC0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_idle got=%b exp=0", out_valid); end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_latency got=%b exp=1", out_valid); end
        n_cmp++; if (out_tag !== 32'hC0 || out_imm !== v_imm[2]) begin
            n_err++; $display("FAIL mid_data got=%h/%h exp=%h/%h", out_tag, out_imm, 32'hC0, v_imm[2]);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_dup got=%b exp=0", out_valid); end
    endtask

    // 64-bit instance: 6-bit shamt, OP-IMM-32 and wide sign extension
    task automatic test_xlen64();
        logic [31:0] ins [5];
        exp64_t      ex  [5];
        exp64_t      e;
        int          i = 0;
        int          o64 = 0;
        logic        acc, cons;
        ins[0] = 32'h4210D093; ex[0] = '{tag: 16'h6400, imm: 64'd33, fmt: 3'd6, unk: 1'b0};
        ins[1] = 32'h80000037; ex[1] = '{tag: 16'h6401, imm: 64'hFFFFFFFF80000000, fmt: 3'd4, unk: 1'b0};
        ins[2] = 32'h4210D09B; ex[2] = '{tag: 16'h6402, imm: 64'd1, fmt: 3'd6, unk: 1'b0};
        ins[3] = 32'hFE000EE3; ex[3] = '{tag: 16'h6403, imm: 64'hFFFFFFFFFFFFFFFC, fmt: 3'd3, unk: 1'b0};
        ins[4] = 32'hFFF0001B; ex[4] = '{tag: 16'h6404, imm: 64'hFFFFFFFFFFFFFFFF, fmt: 3'd1, unk: 1'b0};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            v64_out_ready = 1'b1;
            v64_in_valid  = (i < 5);
            v64_in_instr  = (i < 5) ? ins[i] : 32'h0;
            v64_in_tag    = (i < 5) ? ex[i].tag : 16'h0;
            n_cmp++; if (v64_out_valid !== (o64 > 0)) begin n_err++; $display("FAIL x64_out_valid cyc=%0d got=%b exp=%b", c, v64_out_valid, o64 > 0); end
            cons = v64_out_ready && (o64 > 0);
            acc  = v64_in_valid && (o64 < 2);
            if (cons) begin
                if (sb64.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL x64_extra got tag=%h exp=none", v64_out_tag);
                end else begin
                    e = sb64.pop_front();
                    n_cmp++; if (v64_out_imm !== e.imm) begin n_err++; $display("FAIL x64_imm tag=%h got=%h exp=%h", e.tag, v64_out_imm, e.imm); end
                    n_cmp++; if (v64_out_fmt !== e.fmt || v64_out_unknown !== e.unk) begin
                        n_err++; $display("FAIL x64_fmt tag=%h got=%0d/%b exp=%0d/%b", e.tag, v64_out_fmt, v64_out_unknown, e.fmt, e.unk);
                    end
                    n_cmp++; if (v64_out_tag !== e.tag) begin n_err++; $display("FAIL x64_tag got=%h exp=%h", v64_out_tag, e.tag); end
                end
            end
            if (acc) begin
                sb64.push_back(ex[i]);
                i++;
            end
            o64 = o64 + (acc ? 1 : 0) - (cons ? 1 : 0);
            if (i == 5 && o64 == 0) break;
        end
        v64_in_valid = 1'b0;
        n_cmp++; if (sb64.size() != 0 || i != 5) begin
            n_err++; $display("FAIL x64_drain got pending=%0d sent=%0d exp pending=0 sent=5", sb64.size(), i);
        end
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_decode();
        test_back_to_back();
        test_reset_midstream();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
